// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types for the instruction assembler: immediate formats,
// opcode constants, immediate range limits and the assembler FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } asm_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Byte-unit limits of each immediate format; B and J must also be even.
  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -(1 << 20);
  localparam int IMM_J_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/instr_assembler_imm_pack.sv
// Combinational RV32I packer: scatters the immediate exactly as the decoder
// gathers it and flags immediates the chosen format cannot represent.
module imm_pack
  import riscv_pkg::*;
(
  input  imm_src_t           src,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [31:0] imm,
  output logic [31:0]        word,
  output logic               range_err
);

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    case (src)
      IMM_I: begin
        word      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = (imm < IMM_IS_MIN) || (imm > IMM_IS_MAX);
      end
      IMM_S: begin
        word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = (imm < IMM_IS_MIN) || (imm > IMM_IS_MAX);
      end
      IMM_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = (imm < IMM_B_MIN) || (imm > IMM_B_MAX) || imm[0];
      end
      IMM_J: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = (imm < IMM_J_MIN) || (imm > IMM_J_MAX) || imm[0];
      end
      default: begin
        word      = '0;
        range_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Packs a stream of field-level encode requests into RV32I words written to
// consecutive imem addresses. Optional range rejection: ASM_RANGE_CHECK_EN.
module instr_assembler
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_last_i,
  input  logic [1:0]        req_src_i,
  input  logic [6:0]        req_opcode_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [31:0]       req_imm_i,
  output logic              wr_en_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  asm_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              seq_start, accept, wr_done, load_word;

  logic [31:0]       word_p0;
  logic              range_err_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       word_p1;

  assign seq_start   = (state == ST_IDLE) && start_i;
  assign req_ready_o = (state == ST_LOAD) && (!vld_p1 || wr_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign wr_done     = vld_p1 && wr_ready_i;

  // Stage p0: combinational field packing of the presented request
  imm_pack u_pack (
    .src       (imm_src_t'(req_src_i)),
    .opcode    (req_opcode_i),
    .funct3    (req_funct3_i),
    .rd        (req_rd_i),
    .rs1       (req_rs1_i),
    .rs2       (req_rs2_i),
    .imm       ($signed(req_imm_i)),
    .word      (word_p0),
    .range_err (range_err_p0)
  );

`ifdef ASM_RANGE_CHECK_EN
  logic             reject;
  logic             err_p1;
  logic [CNT_W-1:0] err_cnt;

  // Rejected requests still complete the handshake so the stream never stalls.
  assign load_word = accept && !range_err_p0;
  assign reject    = accept && range_err_p0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_p1  <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_p1 <= reject;
      if (seq_start)   err_cnt <= '0;
      else if (reject) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign err_o     = err_p1;
  assign err_cnt_o = err_cnt;
`else
  logic unused_range_err;

  assign unused_range_err = range_err_p0;
  assign load_word        = accept;
  assign err_o            = 1'b0;
  assign err_cnt_o        = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (seq_start)              state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && req_last_i)   state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_p1)                state_nxt = ST_DONE;
      ST_DONE:                              state_nxt = ST_IDLE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr     <= '0;
      word_cnt <= '0;
    end else if (seq_start) begin
      addr     <= base_addr_i;
      word_cnt <= '0;
    end else begin
      if (load_word) addr     <= addr + ADDR_W'(4);
      if (wr_done)   word_cnt <= sat_inc(word_cnt);
    end
  end

  // Stage p1: output register, held until imem accepts; refills in the drain cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      word_p1 <= '0;
    end else if (load_word) begin
      vld_p1  <= 1'b1;
      addr_p1 <= addr;
      word_p1 <= word_p0;
    end else if (wr_done) begin
      vld_p1  <= 1'b0;
    end
  end

  assign wr_en_o    = vld_p1;
  assign wr_addr_o  = addr_p1;
  assign wr_data_o  = word_p1;
  assign done_o     = (state == ST_DONE);
  assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: scoreboard of expected writes plus a
// decoder-based reference that re-derives every field from the written word.
module tb_instr_assembler;
  import riscv_pkg::*;

`ifdef ASM_RANGE_CHECK_EN
  localparam bit RC_ON = 1'b1;
`else
  localparam bit RC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_last = 1'b0;
  logic [1:0]  req_src = '0;
  logic [6:0]  req_op = '0;
  logic [2:0]  req_f3 = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_addr, wr_data;
  logic        done;
  logic [15:0] word_cnt, err_cnt;
  logic        err;

  always #5 clk = ~clk;

  instr_assembler #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_last_i(req_last),
    .req_src_i(req_src), .req_opcode_i(req_op), .req_funct3_i(req_f3),
    .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_imm_i(req_imm),
    .wr_en_o(wr_en), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .done_o(done), .word_cnt_o(word_cnt), .err_o(err), .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  src;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    int          imm;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] log_addr[$], log_data[$];
  int          checks = 0, errors = 0;
  bit          in_load = 0, drain = 0, done_next = 0, err_next = 0;
  logic [31:0] m_addr = '0;
  int          m_words = 0, m_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [1:0] src, input int imm);
    case (src)
      2'd0, 2'd1: return imm >= -2048 && imm <= 2047;
      2'd2:       return imm >= -4096 && imm <= 4094 && (imm & 1) == 0;
      default:    return imm >= -(1 << 20) && imm <= (1 << 20) - 2 && (imm & 1) == 0;
    endcase
  endfunction

  // The immediate the decoder must see: low bits kept, sign taken from the top kept bit.
  function automatic int trunc_imm(input logic [1:0] src, input int imm);
    int w, u;
    w = (src <= 2'd1) ? 12 : (src == 2'd2) ? 13 : 21;
    u = imm & ((1 << w) - 1);
    if (u >= (1 << (w - 1))) u = u - (1 << w);
    if (src >= 2'd2) u = u & ~1;
    return u;
  endfunction

  function automatic int dec_imm(input logic [1:0] src, input logic [31:0] w);
    logic signed [11:0] t12;
    logic signed [12:0] t13;
    logic signed [20:0] t21;
    case (src)
      2'd0: begin t12 = w[31:20]; return int'(t12); end
      2'd1: begin t12 = {w[31:25], w[11:7]}; return int'(t12); end
      2'd2: begin t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'(t13); end
      default: begin t21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; return int'(t21); end
    endcase
  endfunction

  function automatic bit fields_ok(input req_t e, input logic [31:0] w);
    bit ok;
    ok = (w[6:0] == e.op) && (dec_imm(e.src, w) == trunc_imm(e.src, e.imm));
    case (e.src)
      2'd0:       ok &= (w[11:7] == e.rd) && (w[14:12] == e.f3) && (w[19:15] == e.rs1);
      2'd1, 2'd2: ok &= (w[14:12] == e.f3) && (w[19:15] == e.rs1) && (w[24:20] == e.rs2);
      default:    ok &= (w[11:7] == e.rd);
    endcase
    return ok;
  endfunction

  // Reference model and per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    bit exp_done, exp_err, exp_ready, idle;
    req_t e;
    if (!rst_n) begin
      check("rst_wr_en", 64'(wr_en), 64'(0));
      exp_q.delete();
      in_load = 0; drain = 0; done_next = 0; err_next = 0;
      m_words = 0; m_errs = 0;
    end else begin
      idle      = !in_load && !drain && !done_next;
      exp_done  = done_next; done_next = 0;
      exp_err   = err_next;  err_next  = 0;
      exp_ready = in_load && (exp_q.size() == 0 || wr_ready);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("wr_en", 64'(wr_en), 64'(exp_q.size() != 0));
      check("done", 64'(done), 64'(exp_done));
      check("word_cnt", 64'(word_cnt), 64'(m_words));
      check("err", 64'(err), 64'(exp_err));
      check("err_cnt", 64'(err_cnt), 64'(m_errs));
      if (drain && exp_q.size() == 0) begin
        done_next = 1; drain = 0;
      end
      if (wr_en && exp_q.size() != 0) begin
        e = exp_q[0];
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        checks++;
        if (!fields_ok(e, wr_data)) begin
          errors++;
          $display("FAIL wr_word: got %08h, required src %0d op %02h imm %0d", wr_data, e.src, e.op,
                   trunc_imm(e.src, e.imm));
        end
        if (wr_ready) begin
          void'(exp_q.pop_front());
          log_addr.push_back(wr_addr);
          log_data.push_back(wr_data);
          if (m_words < 65535) m_words++;
        end
      end
      if (req_valid && exp_ready) begin
        if (!RC_ON || in_range(req_src, int'(req_imm))) begin
          exp_q.push_back('{m_addr, req_src, req_op, req_f3, req_rd, req_rs1, req_rs2, int'(req_imm)});
          m_addr = m_addr + 32'd4;
        end else begin
          if (m_errs < 65535) m_errs++;
          err_next = 1;
        end
        if (req_last) begin in_load = 0; drain = 1; end
      end
      if (start && idle) begin
        in_load = 1; m_addr = base; m_words = 0; m_errs = 0;
      end
    end
  end

  task automatic start_seq(input logic [31:0] b);
    start = 1'b1; base = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input int imm, input bit last);
    bit ok = 0;
    req_src = s; req_op = op; req_f3 = f3; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm = imm; req_last = last; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("send_accepted", 64'(ok), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0; req_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check("done_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 64'(wr_en), 64'(0));
    check("reset_wr_addr", 64'(wr_addr), 64'(0));
    check("reset_wr_data", 64'(wr_data), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_word_cnt", 64'(word_cnt), 64'(0));
    check("reset_err_cnt", 64'(err_cnt), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single I-type word
    n0 = log_data.size();
    start_seq(32'h100);
    send(IMM_I, 7'h03, 3'd2, 5'd6, 5'd9, 5'd0, -4, 1);
    wait_done();
    check("i_word", 64'(log_data[n0]), 64'(32'hFFC4A303));
    check("i_addr", 64'(log_addr[n0]), 64'(32'h100));
    check("i_word_cnt", 64'(word_cnt), 64'(1));

    // S then B, with a start pulse mid-sequence that must be ignored
    n0 = log_data.size();
    start_seq(32'h200);
    send(IMM_S, 7'h23, 3'd2, 5'd0, 5'd9, 5'd6, 8, 0);
    start_seq(32'h900);
    send(IMM_B, 7'h63, 3'd2, 5'd0, 5'd9, 5'd6, -8, 1);
    wait_done();
    check("s_word", 64'(log_data[n0]), 64'(32'h0064A423));
    check("b_word", 64'(log_data[n0+1]), 64'(32'hFE64ACE3));
    check("b_addr", 64'(log_addr[n0+1]), 64'(32'h204));
    check("s_reimm", 64'(dec_imm(2'd1, log_data[n0])), 64'(8));
    check("b_reimm", 64'(dec_imm(2'd2, log_data[n0+1])), 64'(-8));

    // Back-pressure: second request held valid while imem stalls three cycles
    n0 = log_data.size();
    start_seq(32'h300);
    wr_ready = 1'b0;
    send(IMM_I, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 5, 0);
    fork
      send(IMM_I, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, -7, 1);
      begin repeat (3) @(posedge clk); #1; wr_ready = 1'b1; end
    join
    wait_done();
    check("stall_word", 64'(log_data[n0]), 64'(32'h00510093));
    check("stall_count", 64'(log_data.size() - n0), 64'(2));
    check("stall_addr2", 64'(log_addr[n0+1]), 64'(32'h304));

    // Address wrap
    n0 = log_data.size();
    start_seq(32'hFFFF_FFFC);
    send(IMM_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1, 0);
    send(IMM_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 2, 1);
    wait_done();
    check("wrap_addr0", 64'(log_addr[n0]), 64'(32'hFFFF_FFFC));
    check("wrap_addr1", 64'(log_addr[n0+1]), 64'(32'h0));

    // Format boundaries
    n0 = log_data.size();
    start_seq(32'h380);
    send(IMM_J, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, -(1 << 20), 0);
    send(IMM_B, 7'h63, 3'd1, 5'd0, 5'd3, 5'd4, 4094, 0);
    send(IMM_I, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -2048, 0);
    send(IMM_S, 7'h23, 3'd2, 5'd0, 5'd7, 5'd8, 2047, 1);
    wait_done();
    check("j_min_word", 64'(log_data[n0]), 64'(32'h8000006F));
    check("bound_cnt", 64'(word_cnt), 64'(4));

    // Odd J and oversized I immediates
    n0 = log_data.size();
    start_seq(32'h400);
    send(IMM_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 3, 0);
    send(IMM_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 4096, 1);
    wait_done();
`ifdef ASM_RANGE_CHECK_EN
    check("rc_err_cnt", 64'(err_cnt), 64'(2));
    check("rc_word_cnt", 64'(word_cnt), 64'(0));
    check("rc_no_writes", 64'(log_data.size() - n0), 64'(0));
`else
    check("trunc_word_cnt", 64'(word_cnt), 64'(2));
    check("trunc_j_word", 64'(log_data[n0]), 64'(32'h002000EF));
    check("trunc_i_word", 64'(log_data[n0+1]), 64'(32'h00000093));
`endif

    // Asynchronous reset with a word pending
    start_seq(32'h500);
    wr_ready = 1'b0;
    send(IMM_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 9, 0);
    check("pre_rst_wr_en", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 64'(wr_en), 64'(0));
    check("async_rst_ready", 64'(req_ready), 64'(0));
    check("async_rst_addr", 64'(wr_addr), 64'(0));
    wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = log_data.size();
    start_seq(32'h600);
    send(IMM_I, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 12, 1);
    wait_done();
    check("post_rst_addr", 64'(log_addr[n0]), 64'(32'h600));
    check("post_rst_cnt", 64'(word_cnt), 64'(1));

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
